aes_cipher_controller: RTL and testbench
========================================

# aes_cipher_controller

Iterative AES-128 encryption sequencer. Accepts a plaintext block and cipher key over a valid/ready handshake. Runs the initial AddRoundKey and rounds 1–10 one round per clock, reusing a single round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and an on-the-fly key-schedule step. Holds the ciphertext on a valid/ready output until consumed. Sits above the existing round-transform modules as the top-level encryption core.

## Interface
- No parameters; Nk=4 and Nr=10 are fixed constants.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  block can accept (IDLE only)
- plaintext  input  128  input block, byte 0 in bits [127:120]
- key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  result, registered
- busy  output  1  high in RUN or DONE

## Operation
- FSM states:
  - IDLE → RUN on accept (in_valid && in_ready).
  - RUN → DONE after round 10.
  - DONE → IDLE on out_valid && out_ready.
- Accept edge:
  - state_reg ← plaintext ^ key (round 0).
  - rk_reg ← key.
  - round ← 1.
- Each RUN cycle:
  - rk_next = key_step(rk_reg, rcon[round]).
  - For round 1–9: state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next.
  - For round 10: MixColumns is omitted.
  - rk_reg ← rk_next.
  - round increments.
- Round 10 edge: ciphertext ← result, out_valid ← 1, FSM → DONE.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- key_step:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}.
  - w5 = w1^w4, w6 = w2^w5, w7 = w3^w6.
- in_ready = (FSM==IDLE). Inputs are ignored when in_ready is low.
- In DONE, ciphertext and out_valid stay stable until out_ready. out_ready outside DONE is ignored.
- round is a 4-bit counter, valid values 1–10, and never wraps past 10.
- Reset at any point, including mid-RUN:
  - FSM → IDLE.
  - round, state_reg, rk_reg, ciphertext → 0.
  - out_valid → 0.
  - The in-flight block is discarded.
- Reset values: in_ready 1, out_valid 0, ciphertext 0, busy 0.

## Timing
- Acceptance edge = E0. Rounds 1..10 complete on edges E1..E10.
- out_valid rises after E10: 10 cycles accept-to-valid.
- With out_ready held high:
  - Output handshake on E11, IDLE after E11.
  - in_ready high from E11+; next accept earliest at E12.
  - Throughput: one block per 12 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- AES_ROUND_OUT_EN defined:
  - Adds outputs round_valid (1) and round_state (128).
  - round_valid pulses one cycle after each of E0..E10.
  - round_state = state_reg after that round; round_idx (4) gives 0..10.
  - All three outputs reset to 0.
- AES_ROUND_OUT_EN undefined: these ports and their logic are absent.
- Core behaviour and timing are identical either way.

## Structure
- Shared package aes_pkg:
  - Nr constant.
  - FSM state typedef (IDLE/RUN/DONE).
  - rcon table.
  - 128-bit block typedef.
- Sub-module aes_key_step: combinational next-round-key from (rk, rcon). It reuses the S-box already used by SubBytes.
- The existing SubBytes/ShiftRows/MixColumns/AddRoundKey modules are instantiated once each.

## Test plan
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 → ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept. With AES_ROUND_OUT_EN:
  - round 0 = 193de3bea0f4e22b9ac68d2ae9f84808.
  - round 1 = a49c7ff2689f352b6b5bea43026a5049.
  - round 2 = aa8f5f0361dde3ef82d24ad26832469a.
- App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Stimulus: out_ready low for 20 cycles after out_valid; a second in_valid is asserted meanwhile.
  - Response: ciphertext stable, in_ready 0, second block not accepted until one cycle after the output handshake.
- Back-to-back: in_valid held high with both vectors queued → both results correct, in order, 12-cycle spacing.
- Reset mid-RUN:
  - Stimulus: assert reset at round 5 of vector B, then run vector C.1.
  - Response: all outputs 0 immediately, in_ready 1 after release, next block returns the correct C.1 result.
- in_valid pulses while busy → ignored; the result equals the first accepted block only.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types, S-box and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NK      = 4;
  localparam int unsigned NR      = 10;
  localparam int unsigned BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  // FSM encoding kept as plain constants for compatibility with older code
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t IDLE = 2'd0;
  localparam fsm_state_t RUN  = 2'd1;
  localparam fsm_state_t DONE = 2'd2;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup shared by SubBytes and the key schedule
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10; zero outside that range
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_cipher_controller_if.sv
// Input/output handshake bundle of the AES-128 core.
// Optional round-trace signals exist only when AES_ROUND_OUT_EN is defined.
interface aes_cipher_controller_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  block_t     plaintext;
  block_t     key;
  logic       out_valid;
  logic       out_ready;
  block_t     ciphertext;
  logic       busy;
`ifdef AES_ROUND_OUT_EN
  logic       round_valid;
  block_t     round_state;
  logic [3:0] round_idx;
`endif

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
`ifdef AES_ROUND_OUT_EN
    , input round_valid, round_state, round_idx
`endif
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
`ifdef AES_ROUND_OUT_EN
    , output round_valid, round_state, round_idx
`endif
  );

endinterface

// File: rtl/aes_add_round_key.sv
// AddRoundKey: bitwise XOR of state and round key.
module aes_add_round_key
  import aes_pkg::*;
(
  input  block_t dataIn,
  input  block_t roundKey,
  output block_t dataOut
);

  assign dataOut = dataIn ^ roundKey;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: next round key from current key and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  block_t     rkIn,
  input  logic [7:0] rconIn,
  output block_t     rkOut
);

  logic [31:0] w0, w1, w2, w3, rotW, subW, w4, w5, w6, w7;

  assign w0 = rkIn[127:96];
  assign w1 = rkIn[95:64];
  assign w2 = rkIn[63:32];
  assign w3 = rkIn[31:0];

  // RotWord then SubWord on the last word
  assign rotW = {w3[23:0], w3[31:24]};
  assign subW = {sbox(rotW[31:24]), sbox(rotW[23:16]), sbox(rotW[15:8]), sbox(rotW[7:0])};

  assign w4 = w0 ^ subW ^ {rconIn, 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign rkOut = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns: each state column multiplied by the fixed 02/03/01/01 matrix.
module aes_mix_columns
  import aes_pkg::*;
(
  input  block_t dataIn,
  output block_t dataOut
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = dataIn[127-32*c -: 8];
    assign a1 = dataIn[119-32*c -: 8];
    assign a2 = dataIn[111-32*c -: 8];
    assign a3 = dataIn[103-32*c -: 8];
    assign dataOut[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dataOut[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dataOut[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dataOut[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_shift_rows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module aes_shift_rows
  import aes_pkg::*;
(
  input  block_t dataIn,
  output block_t dataOut
);

  // Byte n of the block sits at bits [127-8n -: 8]; byte n = row + 4*col
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign dataOut[127-8*(r+4*c) -: 8] = dataIn[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes: S-box applied to each of the 16 state bytes.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  block_t dataIn,
  output block_t dataOut
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dataOut[8*i +: 8] = sbox(dataIn[8*i +: 8]);
  end

endmodule

// File: rtl/aes_cipher_controller.sv
// Iterative AES-128 encryption core: one round per clock over a shared
// round datapath with on-the-fly key expansion.
// Define AES_ROUND_OUT_EN to add the per-round state trace outputs.
module aes_cipher_controller
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  aes_cipher_controller_if.slave  bus
);

  fsm_state_t fsmState, fsmNext;
  logic [3:0] roundCnt;
  block_t     stateReg, rkReg, ctReg;
  logic       outValidReg, inReadyReg, busyReg;

  block_t     rkNext, sbOut, srOut, mcOut, mixSel, roundOut;
  logic       acceptC, lastRoundC, outFireC;

  assign acceptC    = bus.in_valid && (fsmState == IDLE);
  assign lastRoundC = (fsmState == RUN) && (roundCnt == 4'(NR));
  assign outFireC   = (fsmState == DONE) && outValidReg && bus.out_ready;

  // Shared round datapath; the final round bypasses MixColumns
  aes_key_step      uKeyStep  (.rkIn(rkReg), .rconIn(rcon(roundCnt)), .rkOut(rkNext));
  aes_sub_bytes     uSubBytes (.dataIn(stateReg), .dataOut(sbOut));
  aes_shift_rows    uShiftRows(.dataIn(sbOut), .dataOut(srOut));
  aes_mix_columns   uMixCols  (.dataIn(srOut), .dataOut(mcOut));
  assign mixSel = (roundCnt == 4'(NR)) ? srOut : mcOut;
  aes_add_round_key uAddKey   (.dataIn(mixSel), .roundKey(rkNext), .dataOut(roundOut));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsmState <= IDLE;
    else       fsmState <= fsmNext;
  end

  // FSM next-state logic
  always_comb begin
    fsmNext = fsmState;
    case (fsmState)
      IDLE:    if (acceptC)    fsmNext = RUN;
      RUN:     if (lastRoundC) fsmNext = DONE;
      DONE:    if (outFireC)   fsmNext = IDLE;
      default:                 fsmNext = IDLE;
    endcase
  end

  // Round state, key, counter, result and handshake flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= '0;
      rkReg       <= '0;
      roundCnt    <= '0;
      ctReg       <= '0;
      outValidReg <= 1'b0;
      inReadyReg  <= 1'b1;
      busyReg     <= 1'b0;
    end else begin
      inReadyReg <= (fsmNext == IDLE);
      busyReg    <= (fsmNext != IDLE);
      if (acceptC) begin
        stateReg <= bus.plaintext ^ bus.key;
        rkReg    <= bus.key;
        roundCnt <= 4'd1;
      end else if (fsmState == RUN) begin
        stateReg <= roundOut;
        rkReg    <= rkNext;
        if (roundCnt != 4'(NR)) roundCnt <= roundCnt + 4'd1;
        if (lastRoundC) begin
          ctReg       <= roundOut;
          outValidReg <= 1'b1;
        end
      end
      if (outFireC) outValidReg <= 1'b0;
    end
  end

  assign bus.in_ready   = inReadyReg;
  assign bus.out_valid  = outValidReg;
  assign bus.ciphertext = ctReg;
  assign bus.busy       = busyReg;

`ifdef AES_ROUND_OUT_EN
  logic       roundValidReg;
  block_t     roundStateReg;
  logic [3:0] roundIdxReg;

  // Trace of the state after the initial key add and each round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roundValidReg <= 1'b0;
      roundStateReg <= '0;
      roundIdxReg   <= '0;
    end else begin
      roundValidReg <= acceptC || (fsmState == RUN);
      if (acceptC) begin
        roundStateReg <= bus.plaintext ^ bus.key;
        roundIdxReg   <= 4'd0;
      end else if (fsmState == RUN) begin
        roundStateReg <= roundOut;
        roundIdxReg   <= roundCnt;
      end
    end
  end

  assign bus.round_valid = roundValidReg;
  assign bus.round_state = roundStateReg;
  assign bus.round_idx   = roundIdxReg;
`endif

endmodule

// File: tb/tb_aes_cipher_controller.sv
// Directed bench for aes_cipher_controller using FIPS-197 vectors.
module tb_aes_cipher_controller;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R2_B  = 128'haa8f5f0361dde3ef82d24ad26832469a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   accCyc = 0;

  int           accN, outN;
  int           accT [2];
  int           outT [2];
  logic [127:0] outCt [2];
  logic         prevOv, prevIr;

  aes_cipher_controller_if bus();

  aes_cipher_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expVal);
    end
  endtask

  // Offer a block and return #1 after the accepting edge
  task automatic send(input logic [127:0] p, input logic [127:0] k);
    int n = 0;
    bus.plaintext = p;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    chk("send_in_ready", 128'(bus.in_ready), 128'(1));
    step();
    accCyc       = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid and check latency and result
  task automatic waitOut(input string tag, input logic [127:0] expCt);
    int n = 0;
    while (!bus.out_valid && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(cyc - accCyc), 128'(10));
    chk({tag, "_ct"}, bus.ciphertext, expCt);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    step();
    step();

    // Reset values
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_ciphertext", bus.ciphertext, 128'h0);
    chk("rst_busy", 128'(bus.busy), 128'(0));
    reset = 1'b0;
    step();

    // FIPS-197 App. B
    bus.out_ready = 1'b1;
    send(PT_B, KEY_B);
    chk("b_busy", 128'(bus.busy), 128'(1));
    chk("b_in_ready", 128'(bus.in_ready), 128'(0));
`ifdef AES_ROUND_OUT_EN
    chk("b_r0_valid", 128'(bus.round_valid), 128'(1));
    chk("b_r0_idx", 128'(bus.round_idx), 128'(0));
    chk("b_r0_state", bus.round_state, R0_B);
    step();
    chk("b_r1_idx", 128'(bus.round_idx), 128'(1));
    chk("b_r1_state", bus.round_state, R1_B);
    step();
    chk("b_r2_idx", 128'(bus.round_idx), 128'(2));
    chk("b_r2_state", bus.round_state, R2_B);
`endif
    waitOut("b", CT_B);
    step();
    chk("b_hs_out_valid", 128'(bus.out_valid), 128'(0));
    chk("b_hs_in_ready", 128'(bus.in_ready), 128'(1));

    // FIPS-197 App. C.1
    send(PT_C, KEY_C);
    waitOut("c1", CT_C);
    step();

    // Backpressure with a second block offered while DONE
    bus.out_ready = 1'b0;
    send(PT_B, KEY_B);
    waitOut("bp_first", CT_B);
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_ct_stable", bus.ciphertext, CT_B);
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_hs_out_valid", 128'(bus.out_valid), 128'(0));
    chk("bp_hs_not_accepted", 128'(bus.busy), 128'(0));
    chk("bp_hs_in_ready", 128'(bus.in_ready), 128'(1));
    step();
    accCyc       = cyc;
    bus.in_valid = 1'b0;
    chk("bp_second_accepted", 128'(bus.busy), 128'(1));
    waitOut("bp_second", CT_C);
    step();

    // Back-to-back with in_valid held high
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    accN   = 0;
    outN   = 0;
    accT   = '{0, 0};
    outT   = '{0, 0};
    outCt  = '{128'h0, 128'h0};
    prevOv = 1'b0;
    for (int n = 0; n < 60 && outN < 2; n++) begin
      prevIr = bus.in_ready;
      step();
      if (prevIr && bus.in_valid && accN < 2) begin
        accT[accN] = cyc;
        accN++;
        if (accN == 1) begin
          bus.plaintext = PT_C;
          bus.key       = KEY_C;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid && !prevOv) begin
        outT[outN]  = cyc;
        outCt[outN] = bus.ciphertext;
        outN++;
      end
      prevOv = bus.out_valid;
    end
    chk("b2b_out_count", 128'(outN), 128'(2));
    chk("b2b_ct0", outCt[0], CT_B);
    chk("b2b_ct1", outCt[1], CT_C);
    chk("b2b_latency", 128'(outT[0] - accT[0]), 128'(10));
    chk("b2b_accept_spacing", 128'(accT[1] - accT[0]), 128'(12));
    chk("b2b_out_spacing", 128'(outT[1] - outT[0]), 128'(12));
    bus.in_valid = 1'b0;
    step();

    // Reset during round 5 of vector B
    send(PT_B, KEY_B);
    repeat (4) step();
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ciphertext", bus.ciphertext, 128'h0);
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
`ifdef AES_ROUND_OUT_EN
    chk("mid_rst_round_valid", 128'(bus.round_valid), 128'(0));
    chk("mid_rst_round_state", bus.round_state, 128'h0);
`endif
    step();
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_rst_busy", 128'(bus.busy), 128'(0));
    send(PT_C, KEY_C);
    waitOut("post_rst_c1", CT_C);
    step();

    // in_valid pulses while busy are ignored
    send(PT_B, KEY_B);
    step();
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.in_valid  = 1'b1;
    step();
    chk("ign_in_ready", 128'(bus.in_ready), 128'(0));
    bus.in_valid = 1'b0;
    step();
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    waitOut("ign", CT_B);
    step();
    chk("ign_hs_out_valid", 128'(bus.out_valid), 128'(0));
    step();
    step();
    chk("ign_no_extra_accept", 128'(bus.busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
